tpu_mm_sequencer: RTL and testbench
===================================

TPU_MM_SEQUENCER -- requirements
Module: tpu_mm_sequencer

Interface
REQ-001 Parameter SIZE, default 8: array dimension (SIZE x SIZE matrices, legal 2..16).
REQ-002 Parameter DW, default 16: element width (FP16 bit pattern).
REQ-003 Parameter AW, default 8: host address width; SIZE*SIZE SHALL be <= 2**AW.
REQ-004 Parameter DRAIN_CYC, default 10: array pipeline flush cycles after the last feed, legal 1..255.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 host_sel  in  2  bank select: 00=A, 01=B, 10=result, 11=none.
REQ-008 host_addr  in  AW  element index row*SIZE+col.
REQ-009 host_wdata  in  DW  write data; host_we  in  1  write strobe.
REQ-010 host_rdata  out  DW  registered read data.
REQ-011 start  in  1  level-sampled start request; act_sel  in  1  0=none, 1=ReLU.
REQ-012 busy  out  1; done  out  1 pulse; start_err  out  1 pulse; wr_err  out  1 sticky.
REQ-013 arr_clear, arr_en  out  1 each  array accumulator clear and enable.
REQ-014 arr_a  out  SIZE*DW  row feeds, lane i at [i*DW +: DW]; arr_w  out  SIZE*DW  column feeds.
REQ-015 arr_res  in  SIZE*SIZE*DW  array accumulators, element (r,c) at [(r*SIZE+c)*DW +: DW].

Function
REQ-016 Three banks of SIZE*SIZE x DW: A, B, R; the host reads all three and writes A/B/R only while idle.
REQ-017 host_rdata SHALL equal bank[host_sel][host_addr] one cycle after the address is presented; 0 for host_sel=11 or host_addr >= SIZE*SIZE.
REQ-018 Writes with host_addr >= SIZE*SIZE or host_sel=11 SHALL be dropped silently.
REQ-019 Host writes while busy=1 SHALL be dropped and set wr_err; wr_err clears only on reset.
REQ-020 FSM states: IDLE, CLEAR, FEED, DRAIN, STORE, DONE.
REQ-021 In IDLE with start=1: go to CLEAR; a host write in that same cycle SHALL be committed and used by the computation.
REQ-022 CLEAR: one cycle, arr_clear=1, arr_en=0.
REQ-023 FEED: SIZE cycles, step k=0..SIZE-1; arr_en=1; arr_a lane i = A[i][k]; arr_w lane j = B[k][j].
REQ-024 DRAIN: DRAIN_CYC cycles, arr_en=1, arr_a=arr_w=0.
REQ-025 STORE: SIZE cycles; in cycle r, R[r][c] <= act(arr_res(r,c)) for all c.
REQ-026 DONE: one cycle, done=1, then IDLE.
REQ-027 busy=1 in CLEAR through STORE and 0 in IDLE and DONE; done is high exactly 2*SIZE+DRAIN_CYC+1 cycles after busy rises.
REQ-028 start=1 in any state other than IDLE SHALL be ignored and pulse start_err for one cycle per such cycle.
REQ-029 act_sel SHALL be sampled on leaving IDLE and held for the whole run.
REQ-030 Outside FEED, arr_a and arr_w SHALL be 0; outside FEED and DRAIN, arr_en SHALL be 0.

Reset
REQ-031 Asynchronous assertion SHALL force IDLE and set busy, done, start_err, wr_err, arr_clear, arr_en, arr_a, arr_w and host_rdata to 0.
REQ-032 Reset mid-run SHALL abort without a done pulse; bank contents are not cleared, and R may hold a partial store.

Configuration
REQ-033 Macro TPU_SEQ_RELU_EN defined: with act_sel=1, act(x) = 0 when x[DW-1]=1, else x.
REQ-034 Macro TPU_SEQ_RELU_EN undefined: act(x) = x, act_sel is ignored, and no activation logic is instantiated.

Verification
REQ-035 Reset, then release: all outputs 0, busy=0; a read of A[0] returns 0 only after the bench has written 0.
REQ-036 SIZE=2, DRAIN_CYC=3, A={1,2,3,4}, B={5,6,7,8} (16'h3C00-style FP16), start one cycle -> arr_clear for 1 cycle; FEED k=0 gives arr_a={A00,A10}, arr_w={B00,B01}; done 8 cycles after busy rises.
REQ-037 Stub arr_res(0,0)=16'hBC00, act_sel=1: read R[0] -> 16'h0000 with TPU_SEQ_RELU_EN, 16'hBC00 without.
REQ-038 start held high for 3 cycles -> one run, start_err high for 2 cycles, exactly one done pulse.
REQ-039 Write A[0]=16'h1234 while busy -> dropped, wr_err=1 and stays 1, read A[0] returns the prior value.
REQ-040 rst_n low during FEED step 1 -> busy=0 and arr_en=0 immediately; no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/tpu_mm_sequencer.sv
// tpu_mm_sequencer: host-loaded SxS matrix-multiply sequencer for a systolic array.
//
// Holds three SIZE*SIZE element banks (A, B, result R). On a start request it
// clears the array accumulators, streams A rows and B columns for SIZE steps,
// lets the array pipeline drain for DRAIN_CYC cycles, then copies the array
// accumulators into R one row per cycle, optionally through ReLU.
//
// Optional feature macro: TPU_SEQ_RELU_EN (ReLU on stored results when act_sel=1).
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   host_sel/addr/wdata/we  host bank access (00=A 01=B 10=R 11=none), addr = row*SIZE+col
//   host_rdata              registered read data (one cycle after the address)
//   start, act_sel          level start request, activation select (sampled at start)
//   busy, done, start_err   run status; done / start_err are one-cycle pulses
//   wr_err                  sticky: host write attempted while busy
//   arr_clear, arr_en       array accumulator clear / enable
//   arr_a, arr_w            row / column feeds, lane i at [i*DW +: DW]
//   arr_res                 array accumulators, (r,c) at [(r*SIZE+c)*DW +: DW]

`ifdef TPU_SEQ_RELU_EN
// Per-lane ReLU on an FP16 bit pattern: negative values (sign set) become zero.
module tpu_mm_act_lane #(
  parameter int DW = 16
) (
  input  logic          en,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y
);
  assign y = (en && x[DW-1]) ? '0 : x;
endmodule
`endif

module tpu_mm_sequencer #(
  parameter int SIZE      = 8,
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int DRAIN_CYC = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             host_sel,
  input  logic [AW-1:0]          host_addr,
  input  logic [DW-1:0]          host_wdata,
  input  logic                   host_we,
  output logic [DW-1:0]          host_rdata,
  input  logic                   start,
  input  logic                   act_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   start_err,
  output logic                   wr_err,
  output logic                   arr_clear,
  output logic                   arr_en,
  output logic [SIZE*DW-1:0]     arr_a,
  output logic [SIZE*DW-1:0]     arr_w,
  input  logic [SIZE*SIZE*DW-1:0] arr_res
);

  localparam int N  = SIZE*SIZE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, STORE, DONE} state_t;

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } host_req_t;

  host_req_t req;
  assign req = '{sel: host_sel, addr: host_addr, we: host_we, wdata: host_wdata};

  // N may equal 2**AW, so compare with one extra bit of headroom.
  logic          addr_ok;
  logic [IW-1:0] idx;
  assign addr_ok = ({1'b0, req.addr} < (AW+1)'(N));
  assign idx     = req.addr[IW-1:0];

  logic [DW-1:0] bank_a [N];
  logic [DW-1:0] bank_b [N];
  logic [DW-1:0] bank_r [N];

  state_t    state;
  logic [7:0] cnt;

  // Feed lanes for the step about to be presented: step 0 when leaving CLEAR,
  // cnt+1 while inside FEED. On the last FEED step the feeds go to zero, so the
  // index is parked at 0 to stay in range.
  logic [7:0]               fk;
  logic [SIZE-1:0][DW-1:0]  feed_a, feed_w;
  always_comb begin
    fk = (state == FEED && cnt != 8'(SIZE-1)) ? cnt + 8'd1 : 8'd0;
    for (int i = 0; i < SIZE; i++) begin
      feed_a[i] = bank_a[IW'(i*SIZE + int'(fk))];
      feed_w[i] = bank_b[IW'(int'(fk)*SIZE + i)];
    end
  end

  // Row of accumulators being stored this cycle; row 0 outside STORE keeps the
  // part-select in range.
  logic [7:0]               rsel;
  logic [SIZE-1:0][DW-1:0]  res_row, act_row;
  always_comb begin
    rsel = (state == STORE) ? cnt : 8'd0;
    for (int c = 0; c < SIZE; c++)
      res_row[c] = arr_res[(int'(rsel)*SIZE + c)*DW +: DW];
  end

`ifdef TPU_SEQ_RELU_EN
  logic act_q;
  for (genvar c = 0; c < SIZE; c++) begin : g_act
    tpu_mm_act_lane #(.DW(DW)) u_act (
      .en (act_q),
      .x  (res_row[c]),
      .y  (act_row[c])
    );
  end
`else
  assign act_row = res_row;
  logic unused_act;
  assign unused_act = act_sel;
`endif

  // Banks: host writes only while not busy; R is also written by STORE, which
  // cannot overlap a host write because busy is high throughout STORE.
  always_ff @(posedge clk) begin
    if (req.we && !busy && addr_ok) begin
      case (req.sel)
        2'b00:   bank_a[idx] <= req.wdata;
        2'b01:   bank_b[idx] <= req.wdata;
        2'b10:   bank_r[idx] <= req.wdata;
        default: ;
      endcase
    end
    if (state == STORE) begin
      for (int c = 0; c < SIZE; c++)
        bank_r[IW'(int'(rsel)*SIZE + c)] <= act_row[c];
    end
  end

  // Registered host read, old-data on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata <= '0;
    end else if (!addr_ok) begin
      host_rdata <= '0;
    end else begin
      case (req.sel)
        2'b00:   host_rdata <= bank_a[idx];
        2'b01:   host_rdata <= bank_b[idx];
        2'b10:   host_rdata <= bank_r[idx];
        default: host_rdata <= '0;
      endcase
    end
  end

  // Sequencer. Outputs are registered and set on the transition into the
  // state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      wr_err    <= 1'b0;
      arr_clear <= 1'b0;
      arr_en    <= 1'b0;
      arr_a     <= '0;
      arr_w     <= '0;
`ifdef TPU_SEQ_RELU_EN
      act_q     <= 1'b0;
`endif
    end else begin
      start_err <= start && (state != IDLE);
      if (req.we && busy) wr_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            arr_clear <= 1'b1;
`ifdef TPU_SEQ_RELU_EN
            act_q     <= act_sel;
`endif
          end
        end
        CLEAR: begin
          state     <= FEED;
          cnt       <= '0;
          arr_clear <= 1'b0;
          arr_en    <= 1'b1;
          arr_a     <= feed_a;
          arr_w     <= feed_w;
        end
        FEED: begin
          if (cnt == 8'(SIZE-1)) begin
            state <= DRAIN;
            cnt   <= '0;
            arr_a <= '0;
            arr_w <= '0;
          end else begin
            cnt   <= cnt + 8'd1;
            arr_a <= feed_a;
            arr_w <= feed_w;
          end
        end
        DRAIN: begin
          if (cnt == 8'(DRAIN_CYC-1)) begin
            state  <= STORE;
            cnt    <= '0;
            arr_en <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STORE: begin
          if (cnt == 8'(SIZE-1)) begin
            state <= DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          arr_clear <= 1'b0;
          arr_en    <= 1'b0;
          arr_a     <= '0;
          arr_w     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mm_sequencer.sv
// Bench for tpu_mm_sequencer at SIZE=2, DRAIN_CYC=3. A cycle-level model
// derives every output from "cycles since the run started" and plain arrays
// for the banks; a negedge process compares it against the DUT each cycle.
// Directed tests add hand-computed literal checks.
module tb_tpu_mm_sequencer;
  localparam int S = 2, DW = 16, AW = 8, D = 3, N = S*S;
  localparam int TDONE = 2*S + D + 1;

  logic clk = 0, rst_n = 0;
  logic [1:0] host_sel = 2'b11;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0, host_rdata;
  logic host_we = 0, start = 0, act_sel = 0;
  logic busy, done, start_err, wr_err, arr_clear, arr_en;
  logic [S*DW-1:0] arr_a, arr_w;
  logic [N*DW-1:0] arr_res = '0;

  tpu_mm_sequencer #(.SIZE(S), .DW(DW), .AW(AW), .DRAIN_CYC(D)) dut (
    .clk(clk), .rst_n(rst_n), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
    .start(start), .act_sel(act_sel), .busy(busy), .done(done),
    .start_err(start_err), .wr_err(wr_err), .arr_clear(arr_clear),
    .arr_en(arr_en), .arr_a(arr_a), .arr_w(arr_w), .arr_res(arr_res));

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_serr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] act_m(input logic [15:0] x, input bit a);
`ifdef TPU_SEQ_RELU_EN
    return (a && x[15]) ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  // ---------------- model ----------------
  int t = -1;                       // cycles since busy rose, -1 = idle
  logic [15:0] ma [N], mb [N], mr [N];
  bit ka [N], kb [N], kr [N];
  logic [15:0] m_rdata = '0;
  bit m_rk = 1, m_serr = 0, m_werr = 0, m_act = 0, m_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = -1; m_rdata = '0; m_rk = 1; m_serr = 0; m_werr = 0;
    end else begin
      m_busy = (t >= 0 && t < TDONE);
      if (host_sel == 2'b11 || host_addr >= N) begin
        m_rdata = '0; m_rk = 1;
      end else begin
        case (host_sel)
          2'b00:   begin m_rdata = ma[host_addr]; m_rk = ka[host_addr]; end
          2'b01:   begin m_rdata = mb[host_addr]; m_rk = kb[host_addr]; end
          default: begin m_rdata = mr[host_addr]; m_rk = kr[host_addr]; end
        endcase
      end
      if (t >= S+D+1 && t <= 2*S+D)
        for (int c = 0; c < S; c++) begin
          mr[(t-S-D-1)*S+c] = act_m(arr_res[((t-S-D-1)*S+c)*DW +: DW], m_act);
          kr[(t-S-D-1)*S+c] = 1;
        end
      if (host_we && m_busy) m_werr = 1;
      else if (host_we && host_sel != 2'b11 && host_addr < N) begin
        case (host_sel)
          2'b00:   begin ma[host_addr] = host_wdata; ka[host_addr] = 1; end
          2'b01:   begin mb[host_addr] = host_wdata; kb[host_addr] = 1; end
          default: begin mr[host_addr] = host_wdata; kr[host_addr] = 1; end
        endcase
      end
      m_serr = start && (t >= 0);
      if (t < 0) begin
        if (start) begin t = 0; m_act = act_sel; end
      end else if (t == TDONE) t = -1;
      else t++;
    end
  end

  logic [S*DW-1:0] ea, ew;
  always @(negedge clk) begin
    ea = '0; ew = '0;
    if (t >= 1 && t <= S)
      for (int i = 0; i < S; i++) begin
        ea[i*DW +: DW] = ma[i*S + t-1];
        ew[i*DW +: DW] = mb[(t-1)*S + i];
      end
    chk("m_busy",  busy,      (t >= 0 && t < TDONE));
    chk("m_done",  done,      (t == TDONE));
    chk("m_clear", arr_clear, (t == 0));
    chk("m_en",    arr_en,    (t >= 1 && t <= S+D));
    chk("m_arr_a", arr_a,     ea);
    chk("m_arr_w", arr_w,     ew);
    chk("m_serr",  start_err, m_serr);
    chk("m_werr",  wr_err,    m_werr);
    if (m_rk) chk("m_rdata", host_rdata, m_rdata);
    if (done) n_done++;
    if (start_err) n_serr++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic wr(input logic [1:0] s, input int a, input logic [15:0] d);
    host_sel = s; host_addr = AW'(a); host_wdata = d; host_we = 1;
    cyc();
    host_we = 0; host_sel = 2'b11;
  endtask

  task automatic rd(input logic [1:0] s, input int a, output logic [15:0] d);
    host_sel = s; host_addr = AW'(a);
    cyc();
    d = host_rdata; host_sel = 2'b11;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 64) begin cyc(); n++; end
  endtask

  logic [15:0] rv;
  int lat, n;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int e = 0; e < N; e++) arr_res[e*DW +: DW] = (e == 0) ? 16'hBC00 : 16'(16'h1000 + e);
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_en", arr_en, 0);
    chk("rst_a", arr_a, 0); chk("rst_rdata", host_rdata, 0); chk("rst_werr", wr_err, 0);

    wr(2'b00, 0, 16'h0000);
    rd(2'b00, 0, rv); chk("rd_a0_zero", rv, 16'h0000);

    wr(2'b00, 0, 16'h3C00); wr(2'b00, 1, 16'h4000); wr(2'b00, 2, 16'h4200); wr(2'b00, 3, 16'h4400);
    wr(2'b01, 0, 16'h4500); wr(2'b01, 1, 16'h4600); wr(2'b01, 2, 16'h4700); wr(2'b01, 3, 16'h4800);
    for (int i = 0; i < N; i++) wr(2'b10, i, 16'h0000);
    wr(2'b00, 4, 16'hDEAD);                   // out of range, dropped
    rd(2'b00, 4, rv); chk("rd_oob", rv, 0);
    rd(2'b11, 1, rv); chk("rd_none", rv, 0);
    rd(2'b00, 2, rv); chk("rd_a2", rv, 16'h4200);

    // run 1: ReLU requested
    act_sel = 1; start = 1; cyc(); start = 0; act_sel = 0;
    chk("r1_clear", arr_clear, 1); chk("r1_clear_en", arr_en, 0); chk("r1_busy", busy, 1);
    cyc();
    chk("r1_k0_a", arr_a, 32'h4200_3C00); chk("r1_k0_w", arr_w, 32'h4600_4500); chk("r1_k0_en", arr_en, 1);
    cyc();
    chk("r1_k1_a", arr_a, 32'h4400_4000); chk("r1_k1_w", arr_w, 32'h4800_4700);
    wait_done(n); lat = 2 + n;
    chk("r1_done_lat", lat, 8);
    cyc();
    rd(2'b10, 0, rv);
`ifdef TPU_SEQ_RELU_EN
    chk("r1_relu_r0", rv, 16'h0000);
`else
    chk("r1_relu_r0", rv, 16'hBC00);
`endif
    rd(2'b10, 3, rv); chk("r1_r3", rv, 16'h1003);

    // start held 3 cycles
    n_done = 0; n_serr = 0;
    start = 1; repeat (3) cyc(); start = 0;
    wait_done(n); cyc(); cyc();
    chk("hold_serr", n_serr, 2); chk("hold_done", n_done, 1);

    // write while busy
    start = 1; cyc(); start = 0; cyc();
    wr(2'b00, 0, 16'h1234);
    chk("werr_set", wr_err, 1);
    wait_done(n); cyc();
    chk("werr_sticky", wr_err, 1);
    rd(2'b00, 0, rv); chk("werr_a0", rv, 16'h3C00);

    // reset during FEED step 1
    n_done = 0;
    start = 1; cyc(); start = 0; cyc(); cyc();
    chk("rst_mid_en_pre", arr_en, 1);
    rst_n = 0; #1;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_en", arr_en, 0); chk("rst_mid_a", arr_a, 0);
    cyc(); cyc();
    rst_n = 1;
    repeat (3) cyc();
    chk("rst_mid_nodone", n_done, 0); chk("rst_mid_werr", wr_err, 0);

    // write committed in the start cycle, no activation
    host_sel = 2'b00; host_addr = 0; host_wdata = 16'h4800; host_we = 1;
    act_sel = 0; start = 1;
    cyc();
    host_we = 0; start = 0; host_sel = 2'b11;
    chk("r2_clear", arr_clear, 1);
    cyc();
    chk("r2_k0_a", arr_a, 32'h4200_4800);
    wait_done(n); lat = 1 + n;
    chk("r2_done_lat", lat, 8);
    cyc();
    rd(2'b10, 0, rv); chk("r2_r0", rv, 16'hBC00);
    chk("r2_werr", wr_err, 0);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
